// File: rtl/resta_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package resta_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam state_e RST_STATE = IDLE;
  localparam logic   RST_BIT   = 1'b0;

  // Bit-counter width; never below one bit.
  function automatic int cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/restador_1b.sv
// Combinational full-subtractor cell: d = a - b - bin, bout = borrow out.
module restador_1b (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/resta_serial.sv
// Bit-serial A-B, LSB first, one bit per clock with Init/Busy/Done handshake.
// Optional RESTA_SIGNED_EN adds the Mode port and signed overflow detection.
module resta_serial
  import resta_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Init,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef RESTA_SIGNED_EN
  input  logic             Mode,
`endif
  output logic [WIDTH-1:0] OutRest,
  output logic             Error,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] reg_a, reg_b, res_sr;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             d, bout, last_bit, err_bit;
  logic [WIDTH-1:0] diff;

  restador_1b u_cell (
    .a   (reg_a[0]),
    .b   (reg_b[0]),
    .bin (borrow),
    .d   (d),
    .bout(bout)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign diff     = {d, res_sr[WIDTH-1:1]};

`ifdef RESTA_SIGNED_EN
  logic mode_q;
  // On the final bit reg_a[0]/reg_b[0] are the operand sign bits and d is the result sign.
  assign err_bit = mode_q ? ((reg_a[0] ^ reg_b[0]) & (d ^ reg_a[0])) : bout;
`else
  assign err_bit = bout;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= RST_STATE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Init) state_nxt = CALC;
      CALC:    if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign Busy = (state == CALC) || (state == DONE);
  assign Done = (state == DONE);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      reg_a   <= '0;
      reg_b   <= '0;
      res_sr  <= '0;
      cnt     <= '0;
      borrow  <= RST_BIT;
      OutRest <= '0;
      Error   <= RST_BIT;
`ifdef RESTA_SIGNED_EN
      mode_q  <= RST_BIT;
`endif
    end else if (state == IDLE && Init) begin
      reg_a   <= A;
      reg_b   <= B;
      res_sr  <= '0;
      cnt     <= '0;
      borrow  <= 1'b0;
      OutRest <= '0;
      Error   <= 1'b0;
`ifdef RESTA_SIGNED_EN
      mode_q  <= Mode;
`endif
    end else if (state == CALC) begin
      res_sr <= diff;
      reg_a  <= {1'b0, reg_a[WIDTH-1:1]};
      reg_b  <= {1'b0, reg_b[WIDTH-1:1]};
      borrow <= bout;
      cnt    <= cnt + 1'b1;
      if (last_bit) begin
        OutRest <= err_bit ? '0 : diff;
        Error   <= err_bit;
      end
    end
  end

endmodule

// File: tb/tb_resta_serial.sv
// Randomised scoreboard bench for resta_serial (WIDTH=8); follows RESTA_SIGNED_EN if defined.
module tb_resta_serial;

  localparam int W = 8;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         Init;
  logic [W-1:0] A, B;
  logic [W-1:0] OutRest;
  logic         Error, Busy, Done;
`ifdef RESTA_SIGNED_EN
  logic         Mode;
`endif

  resta_serial #(.WIDTH(W)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Init   (Init),
    .A      (A),
    .B      (B),
`ifdef RESTA_SIGNED_EN
    .Mode   (Mode),
`endif
    .OutRest(OutRest),
    .Error  (Error),
    .Busy   (Busy),
    .Done   (Done)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           at;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;
  logic [W-1:0] last_res;
  logic         last_err;

  initial forever @(posedge Clock) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic m, input int at);
    exp_t e;
    int   ua, ub, sa, sb, df;
    bit   ovf;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= (1 << (W-1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W-1))) ? ub - (1 << W) : ub;
    if (m) begin
      df  = sa - sb;
      ovf = (df < -(1 << (W-1))) || (df > (1 << (W-1)) - 1);
    end else begin
      ovf = (ua < ub);
    end
    e.err = ovf;
    e.res = ovf ? '0 : W'(ua - ub);
    e.at  = at;
    return e;
  endfunction

  // Monitor: pops on every Done, checks value, error, arrival cycle and pulse width.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        prev_done = 1'b0;
      end else begin
        if (prev_done) chk("done_one_cycle", Done, 1'b0);
        if (Done) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done: Done=1 with no pending operation (cycle %0d)", cyc);
          end else begin
            e = q.pop_front();
            chk("outrest", OutRest, e.res);
            chk("error", Error, e.err);
            chk("done_cycle", cyc, e.at);
          end
        end
        prev_done = Done;
      end
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    exp_t e;
    A = a;
    B = b;
`ifdef RESTA_SIGNED_EN
    Mode = m;
    e = model(a, b, m, cyc + 1 + W);
`else
    e = model(a, b, 1'b0, cyc + 1 + W);
`endif
    Init = 1'b1;
    q.push_back(e);
    last_res = e.res;
    last_err = e.err;
  endtask

  // One pulsed operation; optional Init re-pulse while busy must be ignored.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        input bit repulse);
    int e;
    @(negedge Clock);
    drive(a, b, m);
    e = cyc + 1;
    @(negedge Clock);
    Init = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    chk("busy_calc", Busy, 1'b1);
    chk("outrest_calc_zero", OutRest, '0);
    if (repulse) begin
      Init = 1'b1;
      @(negedge Clock);
      Init = 1'b0;
    end
    while (cyc < e + W) @(negedge Clock);
    @(negedge Clock);
    chk("busy_idle", Busy, 1'b0);
    chk("outrest_hold", OutRest, last_res);
    chk("error_hold", Error, last_err);
  endtask

  initial begin
    int e;
    Reset = 1'b0;
    Init  = 1'b0;
    A     = '0;
    B     = '0;
`ifdef RESTA_SIGNED_EN
    Mode  = 1'b0;
`endif
    repeat (3) @(negedge Clock);
    chk("rst_outrest", OutRest, '0);
    chk("rst_error", Error, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    Reset = 1'b1;

    run_op(8'd6,   8'd2,   1'b0, 1'b0);
    run_op(8'd2,   8'd5,   1'b0, 1'b0);
    run_op(8'hFF,  8'hFF,  1'b0, 1'b1);
    run_op(8'h00,  8'hFF,  1'b0, 1'b0);
    run_op(8'hFF,  8'h00,  1'b0, 1'b0);
    run_op(8'h80,  8'h01,  1'b1, 1'b0);
    run_op(8'hFD,  8'h04,  1'b1, 1'b0);
    run_op(8'h7F,  8'hFF,  1'b1, 1'b0);

    for (int i = 0; i < 30; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));

    // Init held high: re-accepted once the FSM is back in IDLE; inputs scrambled meanwhile.
    @(negedge Clock);
    for (int k = 0; k < 5; k++) begin
      drive(W'($urandom), W'($urandom), 1'($urandom));
      e = cyc + 1;
      do begin
        @(negedge Clock);
        if (cyc < e + W + 1) begin
          A = W'($urandom);
          B = W'($urandom);
        end
      end while (cyc < e + W + 1);
    end
    Init = 1'b0;
    repeat (W + 3) @(negedge Clock);

    // Reset asserted mid-CALC abandons the operation.
    drive(8'd5, 8'd3, 1'b0);
    @(negedge Clock);
    Init = 1'b0;
    repeat (3) @(negedge Clock);
    #2 Reset = 1'b0;
    q.delete();
    #1;
    chk("midrst_outrest", OutRest, '0);
    chk("midrst_error", Error, 1'b0);
    chk("midrst_busy", Busy, 1'b0);
    chk("midrst_done", Done, 1'b0);
    @(negedge Clock);
    Reset = 1'b1;
    run_op(8'd10, 8'd3, 1'b0, 1'b0);

    for (int t = 0; t < 50 && q.size() != 0; t++) @(negedge Clock);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d operations never completed, expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
